// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Purpose : Bundles the command, ALU and response signals of the ALU
//           sequencer into one interface.
// Modports:
//   slave  - the sequencer itself (accepts commands, drives the ALU inputs,
//            presents responses)
//   master - the environment (offers commands, provides the ALU result,
//            consumes responses)
// Signals :
//   cmd_valid/cmd_ready/cmd_opcode/cmd_operand - command handshake
//   alu_a/alu_b/alu_opcode/alu_res             - external combinational ALU
//   rsp_valid/rsp_ready/rsp_data               - response handshake
//   cmd_count                                  - completed-command counter
//   busy                                       - sequencer not in IDLE
// Optional: ALU_SEQUENCER_FLAGS_EN adds rsp_zero / rsp_neg result flags.
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [31:0] cmd_operand;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_res;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [15:0] cmd_count;
    logic        busy;
`ifdef ALU_SEQUENCER_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_neg;
`endif

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_operand, alu_res, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data,
               cmd_count, busy
`ifdef ALU_SEQUENCER_FLAGS_EN
        , output rsp_zero, rsp_neg
`endif
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_operand, alu_res, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_data,
               cmd_count, busy
`ifdef ALU_SEQUENCER_FLAGS_EN
        , input rsp_zero, rsp_neg
`endif
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Purpose : Three-state sequencer (IDLE -> EXEC -> RESP) that feeds an
//           external combinational ALU. A command latches opcode and B
//           operand, the ALU gets one full cycle to settle, then the result
//           is written into the accumulator (ALU A input) and held as the
//           response until the consumer takes it.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_sequencer_if.slave (command, ALU and response signals)
// Optional: define ALU_SEQUENCER_FLAGS_EN to add rsp_zero / rsp_neg, which
//           are captured together with rsp_data.
// ---------------------------------------------------------------------------
module alu_sequencer (
    input  logic          clk,
    input  logic          rst,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       r_state;
    stateT       w_nextState;
    logic [31:0] r_accum;
    logic [31:0] r_operand;
    logic [3:0]  r_opcode;
    logic [31:0] r_rspData;
    logic [15:0] r_cmdCount;
    logic        w_cmdReady;
    logic        w_cmdFire;
    logic        w_rspFire;
`ifdef ALU_SEQUENCER_FLAGS_EN
    logic        r_rspZero;
    logic        r_rspNeg;
`endif

    // cmd_ready is masked by rst so a handshake can never coincide with reset.
    assign w_cmdReady = (r_state == IDLE) && !rst;
    assign w_cmdFire  = bus.cmd_valid && w_cmdReady;
    assign w_rspFire  = (r_state == RESP) && bus.rsp_ready;

    assign bus.cmd_ready  = w_cmdReady;
    assign bus.alu_a      = r_accum;
    assign bus.alu_b      = r_operand;
    assign bus.alu_opcode = r_opcode;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_data   = r_rspData;
    assign bus.cmd_count  = r_cmdCount;
    assign bus.busy       = (r_state != IDLE);
`ifdef ALU_SEQUENCER_FLAGS_EN
    assign bus.rsp_zero   = r_rspZero;
    assign bus.rsp_neg    = r_rspNeg;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: EXEC is always exactly one cycle; RESP waits for the
    // consumer, so it lasts one cycle when rsp_ready is already high.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_cmdFire) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (bus.rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath registers. The accumulator and response only load at the end
    // of EXEC, so a reset during EXEC or RESP discards the command entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_accum    <= 32'h0;
            r_operand  <= 32'h0;
            r_opcode   <= 4'h0;
            r_rspData  <= 32'h0;
            r_cmdCount <= 16'h0;
`ifdef ALU_SEQUENCER_FLAGS_EN
            r_rspZero  <= 1'b0;
            r_rspNeg   <= 1'b0;
`endif
        end else begin
            if (w_cmdFire) begin
                r_opcode  <= bus.cmd_opcode;
                r_operand <= bus.cmd_operand;
            end
            if (r_state == EXEC) begin
                r_accum   <= bus.alu_res;
                r_rspData <= bus.alu_res;
`ifdef ALU_SEQUENCER_FLAGS_EN
                r_rspZero <= (bus.alu_res == 32'h0);
                r_rspNeg  <= bus.alu_res[31];
`endif
            end
            if (w_rspFire) begin
                r_cmdCount <= r_cmdCount + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Purpose : Directed self-checking bench for alu_sequencer. A small ALU
//           model closes the loop on alu_a/alu_b/alu_opcode/alu_res.
//           Expected responses are queued when a command is issued and a
//           separate monitor compares them whenever a response is taken.
// ALU opcodes modelled: 0000 clear, 0010 add, 0100 sub, 0111 load B,
//           0011 and, 0101 or, 0110 xor, others pass A.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    typedef struct {
        logic [31:0] data;
        logic        zero;
        logic        neg;
    } expT;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   rspSeen;
    expT  expQ[$];

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock generation, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU wired to the sequencer's ALU ports.
    always_comb begin
        bus.alu_res = bus.alu_a;
        case (bus.alu_opcode)
            4'b0000: bus.alu_res = 32'h0;
            4'b0010: bus.alu_res = bus.alu_a + bus.alu_b;
            4'b0011: bus.alu_res = bus.alu_a & bus.alu_b;
            4'b0100: bus.alu_res = bus.alu_a - bus.alu_b;
            4'b0101: bus.alu_res = bus.alu_a | bus.alu_b;
            4'b0110: bus.alu_res = bus.alu_a ^ bus.alu_b;
            4'b0111: bus.alu_res = bus.alu_b;
            default: bus.alu_res = bus.alu_a;
        endcase
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Offer one command as soon as the sequencer is ready, queue its expected
    // response and check the latch and two-edge latency along the way.
    // Returns at the falling edge of the first RESP cycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] operand,
                                 input logic [31:0] expData, input logic expZero,
                                 input logic expNeg);
        expT e;
        bit  gotReady;
        gotReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                gotReady = 1'b1;
                break;
            end
        end
        checkOutput("cmdReadyTimeout", 32'(gotReady), 32'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = op;
        bus.cmd_operand = operand;
        e.data = expData;
        e.zero = expZero;
        e.neg  = expNeg;
        expQ.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("execBusy", 32'(bus.busy), 32'd1);
        checkOutput("execRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("latchedB", bus.alu_b, operand);
        checkOutput("latchedOpcode", 32'(bus.alu_opcode), 32'(op));
        @(negedge clk);
        checkOutput("latencyRspValid", 32'(bus.rsp_valid), 32'd1);
    endtask

    // Response monitor: sampled just after the falling edge so the
    // environment's inputs for the coming rising edge are already settled.
    always @(negedge clk) begin
        expT e;
        #1;
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            rspSeen++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", bus.rsp_data, 32'hDEADBEEF);
            end else begin
                e = expQ.pop_front();
                checkOutput("rspData", bus.rsp_data, e.data);
                checkOutput("rspAccum", bus.alu_a, e.data);
`ifdef ALU_SEQUENCER_FLAGS_EN
                checkOutput("rspZero", 32'(bus.rsp_zero), 32'(e.zero));
                checkOutput("rspNeg", 32'(bus.rsp_neg), 32'(e.neg));
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int lastAccept;
        int accepts;
        int rspBefore;
        logic [31:0] acc;

        checks      = 0;
        failures    = 0;
        rspSeen     = 0;
        rst         = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = 4'h0;
        bus.cmd_operand = 32'h0;
        bus.rsp_ready   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("readyDuringReset", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("resetCmdReady", 32'(bus.cmd_ready), 32'd1);
        checkOutput("resetAccum", bus.alu_a, 32'h0);
        checkOutput("resetB", bus.alu_b, 32'h0);
        checkOutput("resetOpcode", 32'(bus.alu_opcode), 32'h0);
        checkOutput("resetRspData", bus.rsp_data, 32'h0);
        checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("resetCount", 32'(bus.cmd_count), 32'd0);
        checkOutput("resetBusy", 32'(bus.busy), 32'd0);

        // Load 4, add 2, subtract 10 with the consumer always ready.
        bus.rsp_ready = 1'b1;
        applyStimulus(4'b0111, 32'd4, 32'd4, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("loadCount", 32'(bus.cmd_count), 32'd1);
        checkOutput("loadAccum", bus.alu_a, 32'd4);
        checkOutput("loadIdleReady", 32'(bus.cmd_ready), 32'd1);
        applyStimulus(4'b0010, 32'd2, 32'd6, 1'b0, 1'b0);
        applyStimulus(4'b0100, 32'd10, 32'hFFFFFFFC, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("subCount", 32'(bus.cmd_count), 32'd3);

        // Clear with the consumer stalled for 5 cycles; a command offered in
        // the middle of the stall must be ignored.
        bus.rsp_ready = 1'b0;
        applyStimulus(4'b0000, 32'd123, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stallRspValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("stallRspData", bus.rsp_data, 32'h0);
            checkOutput("stallCmdReady", 32'(bus.cmd_ready), 32'd0);
            checkOutput("stallCount", 32'(bus.cmd_count), 32'd3);
            bus.cmd_valid   = (i == 1);
            bus.cmd_opcode  = 4'b0111;
            bus.cmd_operand = 32'd55;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checkOutput("stallIgnoredB", bus.alu_b, 32'd123);
        checkOutput("stallIgnoredOpcode", 32'(bus.alu_opcode), 32'h0);
        checkOutput("stallStillValid", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("stallDoneCount", 32'(bus.cmd_count), 32'd4);
        checkOutput("stallDoneReady", 32'(bus.cmd_ready), 32'd1);

        // Reset in the middle of EXEC aborts the command.
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = 4'b0111;
        bus.cmd_operand = 32'd9;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        checkOutput("abortInExec", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abortRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abortAccum", bus.alu_a, 32'h0);
        checkOutput("abortCount", 32'(bus.cmd_count), 32'd0);
        checkOutput("abortCmdReady", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        checkOutput("abortNoLateRsp", 32'(bus.rsp_valid), 32'd0);

        // Reset wins over a simultaneous handshake.
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = 4'b0111;
        bus.cmd_operand = 32'd77;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        #1;
        checkOutput("resetPriorityBusy", 32'(bus.busy), 32'd0);
        checkOutput("resetPriorityB", bus.alu_b, 32'h0);

        // Back-to-back increments with cmd_valid and rsp_ready held high.
        @(negedge clk);
        acc        = 32'h0;
        accepts    = 0;
        lastAccept = 0;
        rspBefore  = rspSeen;
        bus.cmd_opcode  = 4'b0010;
        bus.cmd_operand = 32'd1;
        bus.cmd_valid   = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.cmd_ready) begin
                expT e;
                if (accepts > 0) begin
                    checkOutput("acceptSpacing", 32'(c - lastAccept), 32'd3);
                end
                accepts++;
                lastAccept = c;
                acc  = acc + 32'd1;
                e.data = acc;
                e.zero = 1'b0;
                e.neg  = 1'b0;
                expQ.push_back(e);
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("b2bAccepts", 32'(accepts), 32'd10);
        checkOutput("b2bResponses", 32'(rspSeen - rspBefore), 32'(accepts));
        checkOutput("b2bCount", 32'(bus.cmd_count), 32'(accepts));
        checkOutput("b2bAccum", bus.alu_a, 32'd10);
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
